// File: rtl/bpf_run_ctrl.sv
// bpf_run_ctrl: sequences packet claim, BPF core run, verdict report and buffer release.
// Optional watchdog forced-reject enabled by defining BPF_RUN_WDOG_EN.
module bpf_run_ctrl #(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int WDOG_LIMIT = 4095,
  parameter int WDOG_WIDTH = 13,
  localparam int PLEN_W = SNOOP_FWD_ADDR_WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_ready,
  input  logic [PLEN_W-1:0] pkt_len,
  output logic              buf_claim,
  output logic              cpu_rst,
  input  logic              cpu_acc,
  input  logic              cpu_rej,
  output logic              fwd_valid,
  input  logic              fwd_ready,
  output logic [PLEN_W-1:0] fwd_len,
  output logic              buf_release,
  output logic              timeout,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, REPORT, RELEASE} state_t;
  state_t state_q, state_d;
  logic [PLEN_W-1:0] len_q, len_d, fwd_len_q;
  logic buf_claim_q, cpu_rst_q, fwd_valid_q, buf_release_q, busy_q;
  logic wdog_hit;
`ifdef BPF_RUN_WDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic timeout_q;
  assign wdog_hit = wdog_q == WDOG_WIDTH'(WDOG_LIMIT);
  always_comb wdog_d = state_q == LOAD ? '0 :
                       (state_q == RUN && wdog_q != '1) ? wdog_q + 1'b1 : wdog_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= state_q == RUN && !cpu_acc && !cpu_rej && wdog_hit;
    end
  assign timeout = timeout_q;
`else
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif
  // Reject wins over accept; any verdict wins over the watchdog.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      IDLE: if (pkt_ready) begin
        state_d = LOAD;
        len_d   = pkt_len;
      end
      LOAD:    state_d = RUN;
      RUN:     state_d = cpu_rej ? RELEASE : cpu_acc ? REPORT : wdog_hit ? RELEASE : RUN;
      REPORT:  state_d = fwd_ready ? RELEASE : REPORT;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      fwd_len_q     <= '0;
      buf_claim_q   <= 1'b0;
      cpu_rst_q     <= 1'b1;
      fwd_valid_q   <= 1'b0;
      buf_release_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      fwd_len_q     <= state_d == REPORT ? len_d : '0;
      buf_claim_q   <= state_d == LOAD;
      cpu_rst_q     <= state_d != RUN;
      fwd_valid_q   <= state_d == REPORT;
      buf_release_q <= state_d == RELEASE;
      busy_q        <= state_d != IDLE;
    end
  assign buf_claim   = buf_claim_q;
  assign cpu_rst     = cpu_rst_q;
  assign fwd_valid   = fwd_valid_q;
  assign fwd_len     = fwd_len_q;
  assign buf_release = buf_release_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_bpf_run_ctrl.sv
// tb_bpf_run_ctrl: directed self-checking bench for bpf_run_ctrl.
module tb_bpf_run_ctrl;
  logic clk = 1'b0;
  logic rst, pkt_ready, cpu_acc, cpu_rej, fwd_ready;
  logic [9:0] pkt_len;
  logic buf_claim, cpu_rst, fwd_valid, buf_release, timeout, busy;
  logic [9:0] fwd_len;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bpf_run_ctrl #(.SNOOP_FWD_ADDR_WIDTH(9), .WDOG_LIMIT(15), .WDOG_WIDTH(13)) dut (
    .clk(clk), .rst(rst), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
    .buf_claim(buf_claim), .cpu_rst(cpu_rst), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_len(fwd_len),
    .buf_release(buf_release), .timeout(timeout), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; pkt_ready = 1'b0; pkt_len = '0; cpu_acc = 1'b0; cpu_rej = 1'b0; fwd_ready = 1'b0;
    #3;
    chk("rst_cpu_rst", cpu_rst, 1); chk("rst_busy", busy, 0); chk("rst_claim", buf_claim, 0);
    chk("rst_fwd_len", fwd_len, 0); chk("rst_timeout", timeout, 0); chk("rst_release", buf_release, 0);
    tick(); rst = 1'b0;
    cpu_acc = 1'b1;
    tick(); chk("idle_ignores_verdict", busy, 0);
    cpu_acc = 1'b0;
    // accept at RUN cycle 5, immediate forward
    pkt_len = 10'd60; pkt_ready = 1'b1; fwd_ready = 1'b1;
    tick(); chk("acc_claim", buf_claim, 1); chk("acc_load_cpu_rst", cpu_rst, 1); chk("acc_busy", busy, 1);
    pkt_ready = 1'b0;
    tick(); chk("acc_run_cpu_rst", cpu_rst, 0); chk("acc_claim_pulse", buf_claim, 0);
    repeat (4) tick();
    chk("acc_run5_cpu_rst", cpu_rst, 0); chk("acc_run5_fwd_valid", fwd_valid, 0);
    cpu_acc = 1'b1;
    tick(); chk("acc_fwd_valid", fwd_valid, 1); chk("acc_fwd_len", fwd_len, 60); chk("acc_rep_cpu_rst", cpu_rst, 1);
    cpu_acc = 1'b0;
    tick(); chk("acc_release", buf_release, 1); chk("acc_fwd_drop", fwd_valid, 0); chk("acc_fwd_len0", fwd_len, 0);
    tick(); chk("acc_idle", busy, 0); chk("acc_release_pulse", buf_release, 0);
    // reject at RUN cycle 3
    pkt_len = 10'd128; pkt_ready = 1'b1;
    tick(); pkt_ready = 1'b0;
    tick(); tick(); tick();
    chk("rej_run3", cpu_rst, 0);
    cpu_rej = 1'b1;
    tick(); chk("rej_release", buf_release, 1); chk("rej_no_fwd", fwd_valid, 0); chk("rej_timeout", timeout, 0);
    cpu_rej = 1'b0;
    tick(); chk("rej_idle", busy, 0);
    // simultaneous accept and reject
    pkt_ready = 1'b1;
    tick(); pkt_ready = 1'b0;
    tick(); cpu_acc = 1'b1; cpu_rej = 1'b1;
    tick(); chk("both_release", buf_release, 1); chk("both_no_fwd", fwd_valid, 0);
    cpu_acc = 1'b0; cpu_rej = 1'b0;
    tick(); chk("both_idle", busy, 0); chk("both_no_fwd2", fwd_valid, 0);
    // held REPORT with len change and pkt_ready ignored
    pkt_len = 10'd60; pkt_ready = 1'b1; fwd_ready = 1'b0;
    tick(); pkt_ready = 1'b0; pkt_len = 10'd99;
    tick(); cpu_acc = 1'b1;
    tick(); cpu_acc = 1'b0; pkt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_fwd_valid", fwd_valid, 1); chk("hold_fwd_len", fwd_len, 60); chk("hold_no_claim", buf_claim, 0);
      tick();
    end
    chk("hold_still_report", fwd_valid, 1);
    fwd_ready = 1'b1;
    tick(); chk("hold_release", buf_release, 1);
    tick(); chk("reclaim_idle", busy, 0);
    tick(); chk("reclaim_claim", buf_claim, 1);
    pkt_ready = 1'b0; fwd_ready = 1'b0;
    tick(); cpu_acc = 1'b1;
    tick(); cpu_acc = 1'b0; chk("reclaim_fwd_len", fwd_len, 99); chk("reclaim_fwd_valid", fwd_valid, 1);
    // asynchronous reset mid-REPORT
    #2 rst = 1'b1;
    #1 chk("mid_rst_cpu_rst", cpu_rst, 1); chk("mid_rst_fwd_valid", fwd_valid, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_fwd_len", fwd_len, 0);
    tick(); rst = 1'b0;
    tick(); chk("post_rst_idle", busy, 0);
    // no verdict: watchdog or indefinite wait
    pkt_ready = 1'b1;
    tick(); pkt_ready = 1'b0;
    tick(); chk("wd_run1", cpu_rst, 0);
`ifdef BPF_RUN_WDOG_EN
    repeat (15) tick();
    chk("wd_run16", cpu_rst, 0); chk("wd_run16_timeout", timeout, 0);
    tick(); chk("wd_timeout", timeout, 1); chk("wd_release", buf_release, 1);
    tick(); chk("wd_timeout_pulse", timeout, 0); chk("wd_idle", busy, 0);
`else
    repeat (100) tick();
    chk("nowd_busy", busy, 1); chk("nowd_cpu_rst", cpu_rst, 0); chk("nowd_timeout", timeout, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
